// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority sharing of one fixed-latency word SRAM between fetch and data ports.
// Data wins over fetch; each access runs WAIT_CYCLES SRAM cycles and then pulses the winner's ready once.
module mem_port_arbiter #(
  parameter int BIT_NUMBER  = 32,
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [BIT_NUMBER-1:0] if_addr,
  output logic [BIT_NUMBER-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_r_en,
  input  logic                  d_w_en,
  input  logic [BIT_NUMBER-1:0] d_addr,
  input  logic [BIT_NUMBER-1:0] d_wdata,
  output logic [BIT_NUMBER-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  if_stall,
  output logic                  d_stall,
  output logic [ADDR_BITS-1:0]  sram_addr,
  output logic [BIT_NUMBER-1:0] sram_wdata,
  output logic                  sram_we,
  output logic                  sram_oe,
  input  logic [BIT_NUMBER-1:0] sram_rdata
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be >= 1");
  end
  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic                  r_gnt_d, r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [BIT_NUMBER-1:0] r_wdata, r_if_rdata, r_d_rdata;
  logic                  w_d_req, w_req, w_last, w_done;
  logic                  w_unused;
  assign w_d_req = d_r_en | d_w_en;
  assign w_req   = w_d_req | if_req;
  assign w_last  = r_state == ACCESS && r_cnt == '0;
  assign w_done  = r_state == DONE;
  // upper and byte-offset address bits are intentionally dropped so addresses wrap
  assign w_unused = ^{if_addr[BIT_NUMBER-1:ADDR_BITS+2], if_addr[1:0],
                      d_addr[BIT_NUMBER-1:ADDR_BITS+2], d_addr[1:0]};
  always_comb begin
    w_state_nxt = r_state == IDLE   ? (w_req  ? ACCESS : IDLE)
                : r_state == ACCESS ? (w_last ? DONE : ACCESS)
                : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gnt_d    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_req) begin
        r_gnt_d <= w_d_req;
        r_we    <= w_d_req & d_w_en;
        r_addr  <= w_d_req ? d_addr[ADDR_BITS+1:2] : if_addr[ADDR_BITS+1:2];
        r_wdata <= d_wdata;
        r_cnt   <= CW'(WAIT_CYCLES - 1);
      end
      if (r_state == ACCESS && !w_last) r_cnt <= r_cnt - 1'b1;
      if (w_last && !r_we && r_gnt_d) r_d_rdata <= sram_rdata;
      if (w_last && !r_we && !r_gnt_d) r_if_rdata <= sram_rdata;
    end
  end
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_we    = r_state == ACCESS && r_we;
  assign sram_oe    = r_state == ACCESS && !r_we;
  assign if_ready   = w_done && !r_gnt_d;
  assign d_ready    = w_done && r_gnt_d;
  assign if_rdata   = r_if_rdata;
  assign d_rdata    = r_d_rdata;
  assign if_stall   = if_req & ~if_ready;
  assign d_stall    = w_d_req & ~d_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of the arbiter against a transaction-level model.
// Expected timing comes from slot arithmetic (W+2 cycles per access); expected data from a reference memory.
module tb_mem_port_arbiter;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic        if_req, d_r_en, d_w_en, if_ready, d_ready, if_stall, d_stall, sram_we, sram_oe;
  logic [31:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata, sram_wdata, sram_rdata;
  logic [15:0] sram_addr;
  logic        u1_if_req, u1_d_r_en, u1_d_w_en, u1_if_ready, u1_d_ready, u1_if_stall, u1_d_stall, u1_sram_we, u1_sram_oe;
  logic [31:0] u1_if_addr, u1_d_addr, u1_d_wdata, u1_if_rdata, u1_d_rdata, u1_sram_wdata, u1_sram_rdata;
  logic [15:0] u1_sram_addr;
  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [31:0] exp_if, exp_d;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_r_en(d_r_en), .d_w_en(d_w_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .if_stall(if_stall), .d_stall(d_stall), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_oe(sram_oe), .sram_rdata(sram_rdata));

  mem_port_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .if_req(u1_if_req), .if_addr(u1_if_addr), .if_rdata(u1_if_rdata), .if_ready(u1_if_ready),
    .d_r_en(u1_d_r_en), .d_w_en(u1_d_w_en), .d_addr(u1_d_addr), .d_wdata(u1_d_wdata), .d_rdata(u1_d_rdata),
    .d_ready(u1_d_ready), .if_stall(u1_if_stall), .d_stall(u1_d_stall), .sram_addr(u1_sram_addr),
    .sram_wdata(u1_sram_wdata), .sram_we(u1_sram_we), .sram_oe(u1_sram_oe), .sram_rdata(u1_sram_rdata));

  always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_wdata;
  assign sram_rdata    = mem[sram_addr];
  assign u1_sram_rdata = 32'hA5A5_0000 | {16'h0, u1_sram_addr};

  // One arbitration round starting in an IDLE cycle: data (if any) takes slot 0, fetch the next slot.
  task automatic run_txn(input bit f, input bit dr, input bit dw,
                         input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd);
    bit dreq, cur_f, cur_d, sd, acc, rdy, wr, e_oe, e_we, e_ifr, e_dr;
    int last, s, off;
    logic [15:0] ea;
    dreq = dr | dw;
    last = (int'(dreq) + int'(f)) * (W + 2) - 1;
    cur_f = f;
    cur_d = dreq;
    if_req = f; d_r_en = dr; d_w_en = dw; if_addr = fa; d_addr = da; d_wdata = wd;
    #1;
    checks++;
    if ({if_stall, d_stall} !== {f, dreq}) begin
      errors++;
      $display("FAIL stall_c0 got %b exp %b", {if_stall, d_stall}, {f, dreq});
    end
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      s   = (c - 1) / (W + 2);
      off = (c - 1) % (W + 2) + 1;
      sd  = dreq && s == 0;
      acc = off <= W;
      rdy = off == W + 1;
      wr  = sd && dw;
      ea  = sd ? da[17:2] : fa[17:2];
      e_oe = acc & ~wr; e_we = acc & wr; e_ifr = rdy & ~sd; e_dr = rdy & sd;
      if (rdy && !wr && sd) exp_d = ref_mem[ea];
      if (rdy && !wr && !sd) exp_if = ref_mem[ea];
      if (rdy && wr) ref_mem[ea] = wd;
      checks++;
      if ({sram_oe, sram_we, if_ready, d_ready} !== {e_oe, e_we, e_ifr, e_dr}) begin
        errors++;
        $display("FAIL ctl c=%0d oe/we/ifr/dr got %b exp %b", c, {sram_oe, sram_we, if_ready, d_ready}, {e_oe, e_we, e_ifr, e_dr});
      end
      checks++;
      if ({if_stall, d_stall} !== {cur_f & ~e_ifr, cur_d & ~e_dr}) begin
        errors++;
        $display("FAIL stall c=%0d got %b exp %b", c, {if_stall, d_stall}, {cur_f & ~e_ifr, cur_d & ~e_dr});
      end
      if (acc) begin
        checks++;
        if (sram_addr !== ea || (wr && sram_wdata !== wd)) begin
          errors++;
          $display("FAIL sram_bus c=%0d addr %h exp %h wdata %h exp %h", c, sram_addr, ea, sram_wdata, wd);
        end
      end
      checks++;
      if (if_rdata !== exp_if || d_rdata !== exp_d) begin
        errors++;
        $display("FAIL rdata c=%0d if %h exp %h d %h exp %h", c, if_rdata, exp_if, d_rdata, exp_d);
      end
      if (rdy && sd) begin d_r_en = 1'b0; d_w_en = 1'b0; cur_d = 1'b0; end
      if (rdy && !sd) begin if_req = 1'b0; cur_f = 1'b0; end
    end
    @(posedge clk); #1;
    checks++;
    if ({sram_oe, sram_we, if_ready, d_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after got %b exp 0000", {sram_oe, sram_we, if_ready, d_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({if_ready, d_ready, if_stall, d_stall, sram_we, sram_oe, sram_addr, sram_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy %b%b we %b oe %b addr %h wd %h ifr %h dr %h",
               if_ready, d_ready, sram_we, sram_oe, sram_addr, sram_wdata, if_rdata, d_rdata);
    end
    exp_if = '0;
    exp_d  = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_read();
    mem[4] = 32'hE3A0_0001;
    ref_mem[4] = 32'hE3A0_0001;
    run_txn(1, 0, 0, 32'h0000_0010, 32'h0, 32'h0);
    checks++;
    if (if_rdata !== 32'hE3A0_0001) begin
      errors++;
      $display("FAIL fetch_word got %h exp e3a00001", if_rdata);
    end
  endtask

  task automatic test_data_write();
    run_txn(0, 0, 1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF);
    checks++;
    if (mem[16'h40] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_mem got %h exp deadbeef", mem[16'h40]);
    end
  endtask

  task automatic test_priority();
    run_txn(1, 1, 0, 32'h0000_0200, 32'h0000_0100, 32'h0);
  endtask

  task automatic test_both_en_wrap();
    run_txn(0, 1, 1, 32'h0, 32'h0003_FFFF, 32'h1234_5678);
    checks++;
    if (mem[16'hFFFF] !== 32'h1234_5678) begin
      errors++;
      $display("FAIL wrap_write got %h exp 12345678", mem[16'hFFFF]);
    end
  endtask

  task automatic test_reset_mid_access();
    if_req = 1'b1; if_addr = 32'h0000_0020;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    if_req = 1'b0;
    exp_if = '0;
    exp_d  = '0;
    checks++;
    if ({if_ready, d_ready, sram_we, sram_oe, sram_addr, sram_wdata, if_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy %b%b we %b oe %b addr %h ifr %h", if_ready, d_ready, sram_we, sram_oe, sram_addr, if_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({if_ready, d_ready, sram_oe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 000", {if_ready, d_ready, sram_oe});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(1, 0, 0, 32'h0000_0020, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    int k;
    logic [31:0] fa, da;
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 5);
      fa = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      da = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      run_txn(k == 0 || k >= 3, k == 1 || k == 3 || k == 5, k == 2 || k == 4 || k == 5, fa, da, $urandom);
    end
  endtask

  task automatic test_wait1();
    u1_if_req = 1'b1; u1_if_addr = 32'h0000_0008;
    @(posedge clk); #1;
    checks++;
    if ({u1_sram_oe, u1_if_ready, u1_sram_addr} !== {2'b10, 16'h0002}) begin
      errors++;
      $display("FAIL w1_access got oe %b rdy %b addr %h exp 1 0 0002", u1_sram_oe, u1_if_ready, u1_sram_addr);
    end
    @(posedge clk); #1;
    checks++;
    if ({u1_sram_oe, u1_if_ready, u1_if_rdata} !== {2'b01, 32'hA5A5_0002}) begin
      errors++;
      $display("FAIL w1_ready got oe %b rdy %b data %h exp 0 1 a5a50002", u1_sram_oe, u1_if_ready, u1_if_rdata);
    end
    u1_if_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({u1_sram_oe, u1_if_ready} !== 2'b00) begin
      errors++;
      $display("FAIL w1_idle got %b exp 00", {u1_sram_oe, u1_if_ready});
    end
  endtask

  initial begin
    if_req = 0; d_r_en = 0; d_w_en = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    u1_if_req = 0; u1_d_r_en = 0; u1_d_w_en = 0; u1_if_addr = 0; u1_d_addr = 0; u1_d_wdata = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_fetch_read();
    test_data_write();
    test_priority();
    test_reset_mid_access();
    test_both_en_wrap();
    test_random();
    test_wait1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one single-port, fixed-latency word SRAM between two requesters: instruction fetch (read-only) and the memory stage (read/write).
- Sequences each access over WAIT_CYCLES cycles and returns a one-cycle ready pulse to the granted requester.
- Produces per-port stall signals that the pipeline ORs into its freeze logic.

Parameters:
- BIT_NUMBER, 32, data and byte-address width.
- ADDR_BITS, 16, SRAM word-address width. Word address = addr[ADDR_BITS+1:2].
- WAIT_CYCLES, 4, SRAM cycles per access. Must be >= 1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch read request, level-held until if_ready.
- if_addr  in  BIT_NUMBER  fetch byte address.
- if_rdata  out  BIT_NUMBER  fetched word.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_r_en  in  1  data read request, level-held until d_ready.
- d_w_en  in  1  data write request, level-held until d_ready.
- d_addr  in  BIT_NUMBER  data byte address.
- d_wdata  in  BIT_NUMBER  store data.
- d_rdata  out  BIT_NUMBER  loaded word.
- d_ready  out  1  one-cycle completion pulse for data.
- if_stall  out  1  = if_req & ~if_ready (combinational).
- d_stall  out  1  = (d_r_en | d_w_en) & ~d_ready (combinational).
- sram_addr  out  ADDR_BITS  SRAM word address.
- sram_wdata  out  BIT_NUMBER  SRAM write data.
- sram_we  out  1  SRAM write enable.
- sram_oe  out  1  SRAM output enable.
- sram_rdata  in  BIT_NUMBER  SRAM read data, valid in the last ACCESS cycle.

Behaviour:
- Reset: state IDLE, counter 0, grant none. All outputs 0, including if_rdata, d_rdata and all sram_* outputs.
- Reset mid-access: the access is abandoned, no ready pulse is issued, and state returns to IDLE immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - Fixed priority: data (d_r_en | d_w_en) over fetch (if_req).
  - On any request, latch grant, op, word address, wdata; load counter with WAIT_CYCLES-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS:
  - Drive sram_addr and sram_wdata from the latched values, stable for all WAIT_CYCLES cycles.
  - Assert sram_we for writes or sram_oe for reads, for every ACCESS cycle.
  - Counter decrements each cycle. At counter==0, capture sram_rdata into the granted port's rdata register (reads only) and go to DONE.
- DONE:
  - sram_we = sram_oe = 0.
  - Pulse the granted port's ready for exactly one cycle, then go to IDLE.
- Latency: request first seen in IDLE at cycle t → ACCESS occupies t+1..t+W → ready high at t+W+1 (W = WAIT_CYCLES).
- Back-to-back accesses: the next request is sampled in the IDLE cycle t+W+2, so throughput is one access per W+2 cycles.
- if_rdata / d_rdata: hold their value until the next completed read on the same port. Writes never modify d_rdata.
- Simultaneous fetch and data in IDLE: data is granted. Fetch stays stalled and is granted at the next IDLE if still requested.
- A request arriving while busy is not granted until IDLE. The granted port's request changing mid-access is ignored: the latched op completes and ready still pulses.
- A request still held in the IDLE cycle after ready is treated as a new access. Requesters must drop or advance the request on ready.
- d_r_en & d_w_en both high: treated as a write.
- Address bits [1:0] and bits above ADDR_BITS+1 are ignored; addresses wrap silently.
- Starvation of fetch is permitted by design: the pipeline is frozen while data accesses are pending.

Test Plan:
- W=4, rst pulse then if_req=1, if_addr=0x0000_0010, sram returns 0xE3A0_0001 → sram_addr=4, sram_oe high for 4 cycles; if_ready pulses at cycle 5 with if_rdata=0xE3A0_0001; if_stall high for cycles 0-4.
- d_w_en=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → sram_addr=0x40 and sram_we=1 for 4 cycles with stable data; d_ready pulses at cycle 5; d_rdata unchanged.
- if_req and d_r_en both raised at cycle 0 → data is served first (d_ready at cycle 5); fetch is granted at cycle 6 (if_ready at cycle 11).
- rst asserted during the 2nd ACCESS cycle of a read → all outputs 0 asynchronously; no ready pulse; after release, a new request completes normally with latency 5.
- d_r_en and d_w_en both 1, d_addr=0x3FFFF → treated as a write; sram_addr=0xFFFF (wraps); d_rdata unchanged.
- Rebuild with WAIT_CYCLES=1: read at 0x8 → sram_oe high for 1 cycle; ready at cycle 2.
